host_cpl_mux: RTL and testbench

- Return-path companion to the host submission-queue splitter.
- Merges completions from the local read, local write, remote read and remote write engines into the single host completion queue.
- Uses a fair round-robin arbiter with a registered output stage.
- Keeps per-source completion counters for the debug/status register file.

---
 rtl/host_cpl_mux.sv | 73 +++++++
 tb/tb_host_cpl_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cpl_mux.sv
// host_cpl_mux: round-robin merge of completion sources into one registered host
// completion queue, with per-source accepted-completion counters.
module host_cpl_mux #(
  parameter int N_SRC = 4,
  parameter int CPL_BITS = 64,
  parameter int CNT_BITS = 16,
  localparam int SW = $clog2(N_SRC)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_SRC-1:0]          s_cpl_valid,
  output logic [N_SRC-1:0]          s_cpl_ready,
  input  logic [N_SRC*CPL_BITS-1:0] s_cpl_data,
  output logic                      m_cpl_valid,
  input  logic                      m_cpl_ready,
  output logic [CPL_BITS-1:0]       m_cpl_data,
  output logic [SW-1:0]             m_cpl_src,
  input  logic                      cnt_clr,
  output logic [N_SRC*CNT_BITS-1:0] cpl_cnt,
  output logic                      idle
);
  logic                valid_q, valid_d;
  logic [CPL_BITS-1:0] data_q, data_d;
  logic [SW-1:0]       src_q, src_d, ptr_q, ptr_d, gnt;
  logic [CNT_BITS-1:0] cnt_q [N_SRC];
  logic [CNT_BITS-1:0] cnt_d [N_SRC];
  logic                gnt_v, load, xfer;
  // descending scan so the source closest to ptr is the last (winning) assignment
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (s_cpl_valid[(int'(ptr_q) + k) % N_SRC]) begin
        gnt_v = 1'b1;
        gnt = SW'((int'(ptr_q) + k) % N_SRC);
      end
  end
  assign load = ~valid_q | m_cpl_ready;
  assign xfer = load & gnt_v & aresetn;
  always_comb begin
    s_cpl_ready = '0;
    s_cpl_ready[gnt] = xfer;
  end
  always_comb begin
    valid_d = load ? gnt_v : valid_q;
    data_d = xfer ? s_cpl_data[int'(gnt)*CPL_BITS +: CPL_BITS] : data_q;
    src_d = xfer ? gnt : src_q;
    ptr_d = xfer ? ((int'(gnt) == N_SRC - 1) ? '0 : gnt + 1'b1) : ptr_q;
    for (int i = 0; i < N_SRC; i++)
      cnt_d[i] = (cnt_clr ? '0 : cnt_q[i]) + CNT_BITS'(xfer && int'(gnt) == i);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign cpl_cnt[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
  end
  assign m_cpl_valid = valid_q;
  assign m_cpl_data = data_q;
  assign m_cpl_src = src_q;
  assign idle = ~valid_q & ~|s_cpl_valid;
endmodule

// File: tb/tb_host_cpl_mux.sv
// tb_host_cpl_mux: randomized and directed checks of host_cpl_mux against a behavioural
// model (4-source, 4-bit counters) and a queue scoreboard (2-source build).
module tb_host_cpl_mux;
  logic aclk = 0, aresetn = 0;
  always #5 aclk = ~aclk;
  int checks = 0, errors = 0;

  logic [3:0]   a_valid = 0, a_ready;
  logic [255:0] a_data = 0;
  logic         a_mv, a_mr = 0, a_clr = 0, a_idle;
  logic [63:0]  a_md;
  logic [1:0]   a_ms;
  logic [15:0]  a_cnt;
  host_cpl_mux #(.N_SRC(4), .CPL_BITS(64), .CNT_BITS(4)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .s_cpl_valid(a_valid), .s_cpl_ready(a_ready),
    .s_cpl_data(a_data), .m_cpl_valid(a_mv), .m_cpl_ready(a_mr), .m_cpl_data(a_md),
    .m_cpl_src(a_ms), .cnt_clr(a_clr), .cpl_cnt(a_cnt), .idle(a_idle));

  logic [1:0]   b_valid = 0, b_ready;
  logic [127:0] b_data = 0;
  logic         b_mv, b_mr = 0, b_ms, b_idle;
  logic [63:0]  b_md;
  logic [31:0]  b_cnt;
  host_cpl_mux #(.N_SRC(2), .CPL_BITS(64), .CNT_BITS(16)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_cpl_valid(b_valid), .s_cpl_ready(b_ready),
    .s_cpl_data(b_data), .m_cpl_valid(b_mv), .m_cpl_ready(b_mr), .m_cpl_data(b_md),
    .m_cpl_src(b_ms), .cnt_clr(1'b0), .cpl_cnt(b_cnt), .idle(b_idle));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic reset_dut();
    cyc();
    aresetn = 0;
    cyc();
    cyc();
    aresetn = 1;
  endtask

  // model of the 4-source instance: pointer, output register, counters mod 16
  int mp = 0, mv = 0, ms = 0;
  int mc [4] = '{0, 0, 0, 0};
  logic [63:0] md = 0;

  function automatic int grant();
    for (int k = 0; k < 4; k++) if (a_valid[(mp + k) % 4]) return (mp + k) % 4;
    return -1;
  endfunction

  always @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      mp = 0; mv = 0; ms = 0; md = 0;
      foreach (mc[i]) mc[i] = 0;
    end else begin
      int g;
      bit ld;
      ld = (mv == 0) || a_mr;
      g = ld ? grant() : -1;
      if (a_clr) foreach (mc[i]) mc[i] = 0;
      if (g >= 0) begin
        mc[g] = (mc[g] + 1) % 16;
        md = a_data[g*64 +: 64];
        ms = g;
        mp = (g + 1) % 4;
      end
      if (ld) mv = (g >= 0) ? 1 : 0;
    end

  always @(negedge aclk) begin
    int g;
    logic [3:0] er;
    er = 0;
    if (aresetn && ((mv == 0) || a_mr)) begin
      g = grant();
      if (g >= 0) er[g] = 1'b1;
    end
    chk("s_cpl_ready", a_ready, er);
    chk("m_cpl_valid", a_mv, mv);
    if (mv != 0) begin
      chk("m_cpl_data", a_md, md);
      chk("m_cpl_src", a_ms, ms);
    end
    for (int i = 0; i < 4; i++) chk("cpl_cnt", a_cnt[i*4 +: 4], mc[i]);
    chk("idle", a_idle, (mv == 0) && (a_valid == 0));
  end

  // scoreboard of the 2-source instance
  logic [63:0] q0 [$], q1 [$];
  int b_outs = 0, b_push0 = 0;
  always @(negedge aclk) if (aresetn) begin
    logic [63:0] e;
    if (b_valid[0] && b_ready[0]) begin q0.push_back(b_data[63:0]); b_push0++; end
    if (b_valid[1] && b_ready[1]) q1.push_back(b_data[127:64]);
    if (b_mv && b_mr) begin
      if ((b_ms ? q1.size() : q0.size()) == 0) begin
        checks++; errors++;
        $display("FAIL b_dup: src %0d emitted %0h with nothing outstanding", b_ms, b_md);
      end else begin
        e = b_ms ? q1.pop_front() : q0.pop_front();
        chk("b_order", b_md, e);
      end
      b_outs++;
    end
  end

  int seq_s [8];
  int bseq [2] = '{0, 0};
  logic [1:0] acc;

  initial begin
    a_valid = 4'hf; a_mr = 1;
    cyc();
    @(negedge aclk);
    chk("rst_ready", a_ready, 0);
    chk("rst_valid", a_mv, 0);
    chk("rst_data", a_md, 0);
    chk("rst_src", a_ms, 0);
    chk("rst_cnt", a_cnt, 0);
    cyc();
    aresetn = 1; a_valid = 0;
    cyc();
    a_valid = 4'b0100; a_data[128 +: 64] = 64'h1234;
    @(negedge aclk);
    chk("t1_ready", a_ready, 4'b0100);
    cyc();
    a_valid = 0;
    @(negedge aclk);
    chk("t1_valid", a_mv, 1);
    chk("t1_data", a_md, 64'h1234);
    chk("t1_src", a_ms, 2);
    chk("t1_cnt2", a_cnt[11:8], 1);
    chk("t1_busy", a_idle, 0);
    cyc();
    @(negedge aclk);
    chk("t1_idle", a_idle, 1);

    reset_dut();
    a_valid = 4'hf;
    for (int i = 0; i < 4; i++) a_data[i*64 +: 64] = 64'ha0 + 64'(i);
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge aclk);
      seq_s[i] = int'(a_ms);
    end
    for (int i = 0; i < 8; i++) chk("t2_seq", seq_s[i], i % 4);
    for (int i = 0; i < 4; i++) chk("t2_cnt", a_cnt[i*4 +: 4], 2);
    cyc();
    a_valid = 0;
    cyc();
    a_mr = 0; a_valid = 4'b1010;
    a_data[64 +: 64] = 64'hbeef1; a_data[192 +: 64] = 64'hbeef3;
    cyc();
    repeat (5) begin
      @(negedge aclk);
      chk("t3_ready", a_ready, 0);
      chk("t3_valid", a_mv, 1);
      chk("t3_src", a_ms, 1);
      chk("t3_data", a_md, 64'hbeef1);
      cyc();
    end
    a_mr = 1;
    @(negedge aclk);
    chk("t3_rel_ready", a_ready, 4'b1000);
    cyc();
    a_valid = 0;
    @(negedge aclk);
    chk("t3_next_src", a_ms, 3);
    chk("t3_next_data", a_md, 64'hbeef3);

    reset_dut();
    a_valid = 4'b0001;
    repeat (17) cyc();
    a_valid = 0;
    @(negedge aclk);
    chk("t4_wrap", a_cnt[3:0], 1);
    cyc();
    a_valid = 4'b0010; a_clr = 1;
    cyc();
    a_valid = 0; a_clr = 0;
    @(negedge aclk);
    chk("t4_clr_cnt1", a_cnt[7:4], 1);
    chk("t4_clr_cnt0", a_cnt[3:0], 0);

    cyc();
    a_valid = 4'b0001; a_mr = 0;
    cyc();
    a_valid = 0;
    @(negedge aclk);
    chk("t5_pending", a_mv, 1);
    cyc();
    #2 aresetn = 0;
    #1;
    chk("t5_async_valid", a_mv, 0);
    cyc();
    cyc();
    aresetn = 1; a_valid = 4'b0101; a_mr = 1;
    @(negedge aclk);
    chk("t5_ptr0", a_ready, 4'b0001);
    cyc();
    a_valid = 0;
    @(negedge aclk);
    chk("t5_src", a_ms, 0);

    repeat (400) begin
      cyc();
      a_valid = 4'($urandom);
      a_mr = ($urandom % 4) != 0;
      a_clr = ($urandom % 16) == 0;
      for (int i = 0; i < 8; i++) a_data[i*32 +: 32] = $urandom;
    end
    cyc();
    a_valid = 0; a_clr = 0; a_mr = 1;

    b_mr = 1;
    for (int c = 0; c < 20000 && b_outs < 1000; c++) begin
      @(negedge aclk);
      acc = b_valid & b_ready;
      cyc();
      for (int i = 0; i < 2; i++)
        if (acc[i] || !b_valid[i]) begin
          b_valid[i] = ($urandom % 4) != 0;
          b_data[i*64 +: 64] = {32'(i), 32'(bseq[i])};
          bseq[i]++;
        end
      b_mr = ($urandom % 3) != 0;
    end
    b_valid = 0; b_mr = 1;
    repeat (5) cyc();
    chk("b_count", b_outs >= 1000, 1);
    chk("b_left", q0.size() + q1.size(), 0);
    chk("b_cnt0", b_cnt[15:0], 16'(b_push0));
    chk("b_idle", b_idle, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
